// File: rtl/lfsr_rr_arbiter.sv
// Round-robin burst arbiter sharing one 8-bit Fibonacci LFSR byte engine among NREQ requesters.
// The granted requester gets one byte per cycle until it drops req or hits BURST_MAX bytes.
// An idle cycle always separates consecutive grants.
module lfsr_rr_arbiter #(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned BURST_MAX = 4,
  parameter logic [7:0]  SEED_RST  = 8'h01,
  localparam int unsigned OwnerW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [7:0]        seed,
  input  logic [NREQ-1:0]   req,
  output logic [NREQ-1:0]   gnt,
  output logic [OwnerW-1:0] owner,
  output logic              rnd_valid,
  output logic [7:0]        rnd_data,
  output logic              busy
);

  localparam logic [7:0]        BurstMax = 8'(BURST_MAX);
  localparam logic [OwnerW-1:0] LastIdx  = OwnerW'(NREQ - 1);
  localparam logic [NREQ-1:0]   OneBit   = NREQ'(1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [7:0]          s_q, s_d;
  logic [NREQ-1:0]     gnt_q, gnt_d;
  logic [OwnerW-1:0]   owner_q, owner_d;
  logic [OwnerW-1:0]   ptr_q, ptr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                rnd_valid_q, rnd_valid_d;
  logic [7:0]          rnd_data_q, rnd_data_d;

  logic                win_found;
  logic [OwnerW-1:0]   win_idx;
  logic [7:0]          s_next;

  // Engine step: shift left, feedback from taps 7,6,5,3
  always_comb begin
    s_next = {s_q[6:0], s_q[7] ^ s_q[6] ^ s_q[5] ^ s_q[3]};
  end

  // Round-robin winner search starting at ptr (inclusive)
  always_comb begin
    int unsigned idx;
    idx       = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = OwnerW'(idx);
      end
    end
  end

  // State register and all datapath flops
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      s_q         <= SEED_RST;
      gnt_q       <= '0;
      owner_q     <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      rnd_valid_q <= 1'b0;
      rnd_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      gnt_q       <= gnt_d;
      owner_q     <= owner_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      rnd_valid_q <= rnd_valid_d;
      rnd_data_q  <= rnd_data_d;
    end
  end

  // Next-state: load beats arbitration; a byte is produced only when the engine steps
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    gnt_d       = gnt_q;
    owner_d     = owner_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    rnd_valid_d = 1'b0;
    rnd_data_d  = rnd_data_q;
    if (load) begin
      // All-zero would lock the LFSR, so substitute the reset seed
      s_d     = (seed == 8'h00) ? SEED_RST : seed;
      gnt_d   = '0;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_found) begin
            gnt_d       = OneBit << win_idx;
            owner_d     = win_idx;
            rnd_valid_d = 1'b1;
            rnd_data_d  = s_q;
            s_d         = s_next;
            cnt_d       = 8'd1;
            state_d     = StGrant;
          end
        end
        StGrant: begin
          if (req[owner_q] && (cnt_q < BurstMax)) begin
            rnd_valid_d = 1'b1;
            rnd_data_d  = s_q;
            s_d         = s_next;
            cnt_d       = cnt_q + 8'd1;
          end else begin
            gnt_d   = '0;
            ptr_d   = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Outputs come straight from flops
  always_comb begin
    gnt       = gnt_q;
    owner     = owner_q;
    rnd_valid = rnd_valid_q;
    rnd_data  = rnd_data_q;
    busy      = (state_q == StGrant);
  end

endmodule

// File: tb/tb_lfsr_rr_arbiter.sv
// Self-checking bench for lfsr_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration and byte-stream rules.
module tb_lfsr_rr_arbiter;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned BURST = 4;
  localparam int unsigned OW    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            load;
  logic [7:0]      seed;
  logic [NREQ-1:0] req;
  logic [NREQ-1:0] gnt;
  logic [OW-1:0]   owner;
  logic            rnd_valid;
  logic [7:0]      rnd_data;
  logic            busy;

  lfsr_rr_arbiter #(
    .NREQ      (NREQ),
    .BURST_MAX (BURST),
    .SEED_RST  (8'h01)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .seed      (seed),
    .req       (req),
    .gnt       (gnt),
    .owner     (owner),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int fail_cnt = 0;

  // Behavioural model state
  bit         m_active;
  int         m_owner;
  int         m_ptr;
  int         m_sent;
  logic [7:0] m_s;
  logic [7:0] m_data;
  bit         m_valid;

  logic [7:0] got_q[$];
  int         own_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // LFSR as polynomial feedback: parity of the tapped bits shifts in at the bottom
  function automatic logic [7:0] poly_next(input logic [7:0] s);
    return {s[6:0], ^(s & 8'hE8)};
  endfunction

  task automatic model_reset();
    m_active = 0;
    m_owner  = 0;
    m_ptr    = 0;
    m_sent   = 0;
    m_s      = 8'h01;
    m_data   = 8'h00;
    m_valid  = 0;
  endtask

  task automatic model_update();
    m_valid = 0;
    if (load) begin
      m_s      = (seed == 8'h00) ? 8'h01 : seed;
      m_active = 0;
    end else if (!m_active) begin
      for (int k = 0; k < NREQ; k++) begin
        int j;
        j = (m_ptr + k) % NREQ;
        if (!m_active && req[j]) begin
          m_active = 1;
          m_owner  = j;
          m_sent   = 1;
          m_valid  = 1;
          m_data   = m_s;
          m_s      = poly_next(m_s);
        end
      end
    end else if (req[m_owner] && m_sent < BURST) begin
      m_sent++;
      m_valid = 1;
      m_data  = m_s;
      m_s     = poly_next(m_s);
    end else begin
      m_active = 0;
      m_ptr    = (m_owner + 1) % NREQ;
    end
  endtask

  task automatic compare_all();
    logic [NREQ-1:0] eg;
    eg = m_active ? NREQ'(1 << m_owner) : '0;
    check_eq("gnt", gnt, eg);
    check_eq("owner", owner, m_owner);
    check_eq("rnd_valid", rnd_valid, m_valid);
    check_eq("rnd_data", rnd_data, m_data);
    check_eq("busy", busy, m_active);
    check_eq("valid_onehot", rnd_valid ? $onehot(gnt) : 1'b1, 1'b1);
    if (rnd_valid) got_q.push_back(rnd_data);
    if (rnd_valid && m_sent == 1 && m_valid) own_q.push_back(int'(owner));
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    load = 1'b0;
    seed = 8'h00;
    req  = '0;
    #1;
    check_eq("rst_gnt", gnt, 0);
    check_eq("rst_valid", rnd_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_data", rnd_data, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    got_q.delete();
    own_q.delete();
  endtask

  task automatic check_bytes(input string tag, input logic [7:0] exp[$]);
    check_eq({tag, "_len"}, got_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got_q.size(); i++) check_eq(tag, got_q[i], exp[i]);
  endtask

  initial begin
    logic [7:0] exp_b[$];
    int         exp_o[$];
    rst  = 1'b1;
    load = 1'b0;
    seed = 8'h00;
    req  = '0;
    model_reset();

    // Single requester held: two bursts separated by one idle cycle
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 9; i++) step();
    exp_b = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h22, 8'h45, 8'h8B};
    check_bytes("single_seq", exp_b);

    // All requesting: rotation 0,1,2,3,0
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 25; i++) step();
    exp_o = '{0, 1, 2, 3, 0};
    check_eq("rr_len", own_q.size(), exp_o.size());
    for (int i = 0; i < exp_o.size() && i < own_q.size(); i++) check_eq("rr_order", own_q[i], exp_o[i]);
    check_eq("rr_bytes", got_q.size(), 20);

    // Early release after two bytes, then ptr=3 makes requester 0 win over 2
    do_reset();
    req = 4'b0100;
    step();
    step();
    req = 4'b0000;
    step();
    check_eq("early_gnt0", gnt, 0);
    exp_b = '{8'h01, 8'h02};
    check_bytes("early_seq", exp_b);
    req = 4'b0101;
    step();
    check_eq("early_regrant", gnt, 4'b0001);

    // Load mid-burst aborts; next grant starts from the seed
    do_reset();
    req = 4'b0001;
    step();
    load = 1'b1;
    seed = 8'hA5;
    step();
    load = 1'b0;
    check_eq("load_abort_gnt", gnt, 0);
    check_eq("load_abort_vld", rnd_valid, 0);
    step();
    check_eq("load_first", rnd_data, 8'hA5);
    step();
    check_eq("load_second", rnd_data, 8'h4A);
    load = 1'b1;
    seed = 8'h00;
    step();
    load = 1'b0;
    step();
    check_eq("zero_seed", rnd_data, 8'h01);

    // Load and req together in IDLE: load wins, grant one cycle later
    do_reset();
    req  = 4'b0010;
    load = 1'b1;
    seed = 8'h3C;
    step();
    load = 1'b0;
    check_eq("ld_req_nogrant", gnt, 0);
    step();
    check_eq("ld_req_grant", gnt, 4'b0010);
    check_eq("ld_req_byte", rnd_data, 8'h3C);

    // Async reset mid-cycle during a burst
    step();
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst_gnt", gnt, 0);
    check_eq("arst_valid", rnd_valid, 0);
    check_eq("arst_data", rnd_data, 0);
    check_eq("arst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    req = 4'b1000;
    step();
    check_eq("arst_first", rnd_data, 8'h01);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      req  = NREQ'($urandom_range(0, 15));
      if ($urandom_range(0, 3) != 0) req = req | (m_active ? NREQ'(1 << m_owner) : '0);
      load = ($urandom_range(0, 39) == 0);
      seed = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      step();
    end
    load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", chk_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/lfsr_rr_arbiter.md
Name: lfsr_rr_arbiter

Overview:
- Shares one 8-bit Fibonacci LFSR random-byte engine among NREQ requesters using round-robin bursts.
- Each granted requester receives one pseudo-random byte per cycle until it releases its request or reaches BURST_MAX bytes.
- The block sits between the random-source datapath and the consumers: scramblers, test-pattern generators and noise injectors.
- It also owns reseeding of the shared engine.

Parameters:
- NREQ, 4, number of requesters (2..8).
- BURST_MAX, 4, maximum bytes per grant (1..255).
- SEED_RST, 8'h01, LFSR value after reset, and the substitute for any all-zero seed.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- load  in  1  reseed strobe, sampled on clk.
- seed  in  8  reseed value, used when load=1.
- req  in  NREQ  request per requester, level; held high to continue a burst.
- gnt  out  NREQ  registered one-hot grant; all zero when idle.
- owner  out  max(1,clog2(NREQ))  index of the current/last grantee.
- rnd_valid  out  1  rnd_data carries a fresh byte for the gnt holder this cycle.
- rnd_data  out  8  random byte; holds its last value when rnd_valid=0.
- busy  out  1  high in state GRANT.

Behaviour:
- Engine step: next(s) = {s[6:0], s[7]^s[6]^s[5]^s[3]} (x^8+x^4+x^2+x+1 form). The engine steps only when a byte is delivered.
- Reset (async, immediate, no clock needed): s=SEED_RST, gnt=0, rnd_valid=0, rnd_data=0, owner=0, ptr=0, cnt=0, busy=0, state=IDLE.
- Priority each edge: rst > load > arbitration.
- load=1:
  - s <= (seed==0 ? SEED_RST : seed); gnt <= 0; rnd_valid <= 0; state <= IDLE.
  - Any active burst aborts with no byte that cycle; ptr and owner are unchanged.
- State IDLE, req!=0, load=0:
  - Winner w = first set bit scanning ptr, ptr+1, ... modulo NREQ (ptr inclusive).
  - Next edge: gnt <= onehot(w), owner <= w, rnd_valid <= 1, rnd_data <= s, s <= next(s), cnt <= 1, state <= GRANT.
  - Latency: req sampled high at edge k gives gnt and first byte visible after edge k.
- State IDLE, req==0: outputs hold with rnd_valid=0.
- State GRANT, req[owner]=1 and cnt<BURST_MAX: rnd_valid <= 1, rnd_data <= s, s <= next(s), cnt <= cnt+1.
- State GRANT, req[owner]=0 or cnt==BURST_MAX: burst ends.
  - gnt <= 0, rnd_valid <= 0, ptr <= (owner+1) mod NREQ, state <= IDLE.
  - No byte is delivered on the ending edge.
  - At least one idle cycle always separates consecutive grants.
- Requests from non-owners during GRANT are ignored until IDLE. req bits may change at any time.
- A burst delivers exactly min(BURST_MAX, cycles req[owner] stayed high) bytes.
- No byte is ever delivered while gnt==0. rnd_valid==1 implies gnt is one-hot.
- Reference sequence from 8'h01: 01,02,04,08,11,22,45,8B,...

Test Plan:
- Reset, req=0001 held:
  - gnt=0001 and rnd_data 01,02,04,08 with rnd_valid=1 on 4 consecutive cycles.
  - One cycle with gnt=0, rnd_valid=0.
  - Re-grant to 0 (ptr=1 scan wraps) with bytes 11,22,45,8B.
- req=1111 held: grant order 0,1,2,3,0. Each grant gives 4 bytes, with a 1-cycle gap between grants. The stream continues the single global sequence across owners.
- Early release:
  - req=0100 raised for 2 cycles after grant, then dropped: exactly 2 bytes (01,02), then gnt=0 and ptr=3.
  - Then req=0101: grant goes to 0, not 2.
- Load mid-burst:
  - Second byte of a burst, load=1 with seed=8'hA5: next cycle gnt=0, rnd_valid=0.
  - The next grant delivers A5 then next(A5)=4A.
  - load with seed=00 produces 01 as the first byte.
- Simultaneous load and req in IDLE: load wins, no grant that edge. The grant appears one cycle later with first byte = seed.
- Async rst asserted mid-cycle during a burst: gnt, rnd_valid, rnd_data and busy go to 0 without a clock edge. After release, the first byte is 01.
